conv_window_mac: RTL and testbench

- Downstream consumer of the window-read memory stage: takes the 5x5 signed 16-bit window that memory returns on a read and multiplies it element-wise with a resident 5x5 kernel.
- Accumulates the 25 products, adds a bias, then rounds, saturates and optionally applies ReLU.
- Hands a single 16-bit fixed-point result to the write-back path through a valid/ready handshake.
- Processes one row of five products per cycle.

---
 rtl/conv_window_mac_if.sv | 25 ++
 rtl/conv_window_mac.sv | 145 ++++++++++++++
 tb/tb_conv_window_mac.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/conv_window_mac_if.sv
// Window-in / result-out handshake bundle for conv_window_mac.
// master = upstream memory stage + write-back side, slave = the MAC block.
interface conv_window_mac_if #(
  parameter int K      = 5,
  parameter int DATA_W = 16
);
  logic                             win_valid;
  logic                             win_ready;
  logic [K-1:0][K-1:0][DATA_W-1:0]  window_in;
  logic [DATA_W-1:0]                bias;
  logic                             relu_en;
  logic                             res_valid;
  logic                             res_ready;
  logic [DATA_W-1:0]                result;

  modport master (
    output win_valid, window_in, bias, relu_en, res_ready,
    input  win_ready, res_valid, result
  );

  modport slave (
    input  win_valid, window_in, bias, relu_en, res_ready,
    output win_ready, res_valid, result
  );
endinterface

// File: rtl/conv_window_mac.sv
// 5x5 window x resident kernel MAC, one row of K products per cycle, then
// round-half-up, saturate, optional ReLU, and a valid/ready result.

module conv_mac_lane #(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0]   a,
  input  logic signed [DATA_W-1:0]   b,
  output logic signed [2*DATA_W-1:0] p
);
  assign p = a * b;
endmodule

module conv_window_mac #(
  parameter int K         = 5,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 11,
  parameter int ACC_W     = 40
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            kernel_load,
  input  logic [K-1:0][K-1:0][DATA_W-1:0] kernel_in,
  output logic                            busy,
  conv_window_mac_if.slave                bus
);
  localparam int ROW_W = (K > 1) ? $clog2(K) : 1;
  localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  typedef enum logic [1:0] {IDLE, ACCUM, ROUND, OUT} state_t;

  state_t state, state_nxt;

  logic [K-1:0][K-1:0][DATA_W-1:0] ker_q;
  logic [K-1:0][K-1:0][DATA_W-1:0] win_q;
  logic signed [ACC_W-1:0]         acc;
  logic [ROW_W-1:0]                row;
  logic                            relu_q;
  logic [DATA_W-1:0]               res_q;
  logic                            res_vld;

  logic                            win_rdy;
  logic                            accept;
  logic [K-1:0][DATA_W-1:0]        win_row;
  logic [K-1:0][DATA_W-1:0]        ker_row;
  logic [K-1:0][2*DATA_W-1:0]      prod;
  logic signed [ACC_W-1:0]         row_sum;
  logic signed [ACC_W-1:0]         bias_ext;
  logic signed [ACC_W-1:0]         rnd;
  logic signed [ACC_W-1:0]         shf;
  logic signed [DATA_W-1:0]        sat;
  logic [DATA_W-1:0]               res_nxt;

  assign accept   = bus.win_valid && win_rdy;
  assign win_row  = win_q[row];
  assign ker_row  = ker_q[row];
  assign bias_ext = ACC_W'($signed(bus.bias));

  // One multiplier per column; the row counter walks the window through them.
  for (genvar c = 0; c < K; c++) begin : g_lane
    conv_mac_lane #(.DATA_W(DATA_W)) u_lane (
      .a (win_row[c]),
      .b (ker_row[c]),
      .p (prod[c])
    );
  end

  always_comb begin
    row_sum = '0;
    for (int c = 0; c < K; c++)
      row_sum = row_sum + ACC_W'($signed(prod[c]));
  end

  always_comb begin
    rnd = acc + HALF;
    shf = rnd >>> FRAC_BITS;
    if (shf > SAT_MAX)      sat = DATA_W'(SAT_MAX);
    else if (shf < SAT_MIN) sat = DATA_W'(SAT_MIN);
    else                    sat = DATA_W'(shf);
    res_nxt = (relu_q && sat[DATA_W-1]) ? '0 : sat;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)                       state_nxt = ACCUM;
      ACCUM:   if (row == ROW_W'(K - 1))         state_nxt = ROUND;
      ROUND:                                     state_nxt = OUT;
      OUT:     if (bus.res_ready)                state_nxt = IDLE;
      default:                                   state_nxt = IDLE;
    endcase
  end

  // Output logic; win_ready also held low while reset is asserted
  always_comb begin
    win_rdy = rst_n && (state == IDLE) && !kernel_load;
    busy    = (state != IDLE);
  end

  assign bus.win_ready = win_rdy;
  assign bus.res_valid = res_vld;
  assign bus.result    = res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ker_q   <= '0;
      win_q   <= '0;
      acc     <= '0;
      row     <= '0;
      relu_q  <= 1'b0;
      res_q   <= '0;
      res_vld <= 1'b0;
    end else begin
      // Kernel only changes between windows so the in-flight one is consistent.
      if (state == IDLE && kernel_load) ker_q <= kernel_in;
      case (state)
        IDLE: if (accept) begin
          win_q  <= bus.window_in;
          relu_q <= bus.relu_en;
          acc    <= bias_ext <<< FRAC_BITS;
          row    <= '0;
        end
        ACCUM: begin
          acc <= acc + row_sum;
          row <= row + ROW_W'(1);
        end
        ROUND: begin
          res_q   <= res_nxt;
          res_vld <= 1'b1;
        end
        OUT: if (bus.res_ready) res_vld <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_window_mac.sv
// Directed bench for conv_window_mac: arithmetic, rounding, saturation,
// ReLU, backpressure, kernel_load priority and mid-run reset.
module tb_conv_window_mac;
  localparam int K  = 5;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic kernel_load = 1'b0;
  logic busy;
  logic [K-1:0][K-1:0][DW-1:0] kernel_in = '0;
  int checks = 0;
  int failures = 0;

  conv_window_mac_if #(.K(K), .DATA_W(DW)) bus ();

  conv_window_mac dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .kernel_load (kernel_load),
    .kernel_in   (kernel_in),
    .busy        (busy),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [K-1:0][K-1:0][DW-1:0] grid(input logic [DW-1:0] all,
                                                       input logic [DW-1:0] ctr);
    logic [K-1:0][K-1:0][DW-1:0] g;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        g[r][c] = (r == K/2 && c == K/2) ? ctr : all;
    return g;
  endfunction

  task automatic load_ker(input logic [DW-1:0] all, input logic [DW-1:0] ctr);
    @(negedge clk);
    kernel_in   = grid(all, ctr);
    kernel_load = 1'b1;
    @(negedge clk);
    kernel_load = 1'b0;
  endtask

  // Presents a window for one cycle; returns at the negedge after the accept edge.
  task automatic start_win(input logic [DW-1:0] all, input logic [DW-1:0] ctr,
                           input logic [DW-1:0] b, input logic r);
    @(negedge clk);
    bus.window_in = grid(all, ctr);
    bus.bias      = b;
    bus.relu_en   = r;
    bus.win_valid = 1'b1;
    #1;
    chk("win_ready_idle", bus.win_ready, 1);
    @(negedge clk);
    bus.win_valid = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    while (!bus.res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("res_valid_seen", bus.res_valid, 1);
  endtask

  task automatic finish_res();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("idle_after_hs_busy", busy, 0);
    chk("idle_after_hs_valid", bus.res_valid, 0);
  endtask

  task automatic run(input string tag, input logic [DW-1:0] all, input logic [DW-1:0] ctr,
                     input logic [DW-1:0] b, input logic r,
                     input logic signed [DW-1:0] exp, input bit do_lat);
    int lat;
    start_win(all, ctr, b, r);
    wait_res(lat);
    if (do_lat) chk({tag, "_latency"}, lat, 6);
    chk(tag, $signed(bus.result), exp);
    finish_res();
  endtask

  initial begin
    int lat;
    bit bad;
    bit seen;
    bus.win_valid = 1'b0;
    bus.window_in = '0;
    bus.bias      = '0;
    bus.relu_en   = 1'b0;
    bus.res_ready = 1'b0;

    #12;
    chk("rst_result", bus.result, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_win_ready", bus.win_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 25 * (1.0 * 32) = 800
    load_ker(16'd2048, 16'd2048);
    run("sum_800", 16'd32, 16'd32, 16'd0, 1'b0, 16'sd800, 1'b1);
    // raw +/-25.0 saturates
    run("sat_pos", 16'd2048, 16'd2048, 16'd0, 1'b0, 16'sd32767, 1'b0);
    run("sat_neg", -16'sd2048, -16'sd2048, 16'd0, 1'b0, -16'sd32768, 1'b0);
    run("neg_800", -16'sd32, -16'sd32, 16'd0, 1'b0, -16'sd800, 1'b0);
    run("relu_clamp", -16'sd32, -16'sd32, 16'd0, 1'b1, 16'sd0, 1'b0);
    run("relu_pos_pass", 16'd32, 16'd32, 16'd0, 1'b1, 16'sd800, 1'b0);

    // Center 0.5: 3*1024 = 1.5 LSB -> 2, -1.5 -> -1; bias 1.0 -> 2048
    load_ker(16'd0, 16'd1024);
    run("round_pos_half", 16'd0, 16'd3, 16'd0, 1'b0, 16'sd2, 1'b0);
    run("round_neg_half", 16'd0, -16'sd3, 16'd0, 1'b0, -16'sd1, 1'b0);
    run("bias_only", 16'd0, 16'd0, 16'd2048, 1'b0, 16'sd2048, 1'b0);
    run("bias_plus_prod", 16'd0, 16'd4, -16'sd2048, 1'b0, -16'sd2046, 1'b0);

    // kernel_load wins over win_valid in the same IDLE cycle
    @(negedge clk);
    kernel_in     = grid(16'd2048, 16'd2048);
    kernel_load   = 1'b1;
    bus.window_in = grid(16'd32, 16'd32);
    bus.bias      = '0;
    bus.relu_en   = 1'b0;
    bus.win_valid = 1'b1;
    #1;
    chk("prio_win_ready", bus.win_ready, 0);
    @(negedge clk);
    kernel_load   = 1'b0;
    bus.win_valid = 1'b0;
    #1;
    chk("prio_not_accepted", busy, 0);
    run("prio_new_kernel", 16'd32, 16'd32, 16'd0, 1'b0, 16'sd800, 1'b0);

    // Backpressure: hold res_ready low for 10 cycles
    start_win(16'd32, 16'd32, 16'd0, 1'b0);
    wait_res(lat);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.result !== 16'd800 || bus.res_valid !== 1'b1 ||
          bus.win_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    chk("bp_stable", bad, 0);
    chk("bp_result", $signed(bus.result), 800);
    finish_res();
    chk("bp_win_ready_after", bus.win_ready, 1);

    // Reset while row 2 is being accumulated
    start_win(16'd32, 16'd32, 16'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_win_ready", bus.win_ready, 0);
    chk("midrst_result", bus.result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    chk("midrst_no_spurious", seen, 0);
    run("midrst_cleared_kernel", 16'd32, 16'd32, 16'd0, 1'b0, 16'sd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
